csc_matrix_pipe: RTL and testbench

Parametrised, runtime-programmable 3x3 colour-space converter for the video pixel path: applies a signed fixed-point matrix plus per-channel offset to each PIX_W-bit three-channel pixel, then rounds and clamps. It is the next-generation RGB→YCbCr stage. The fixed BT.601 coefficients are now reset defaults. Coefficients and offsets can be reloaded safely on frame boundaries, and a bypass mode is added. It sits between the video timing source and downstream processing, delaying de/h_sync/v_sync to match its fixed pipeline latency.

---
 rtl/csc_pkg.sv | 13 +
 rtl/csc_mac_row.sv | 63 ++++++
 rtl/csc_matrix_pipe.sv | 94 +++++++++
 tb/tb_csc_matrix_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// csc_pkg: shared constants for the csc_matrix_pipe colour-space converter
package csc_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int COEF_W_DEF = 18;
  localparam int FRAC_W_DEF = 16;
  localparam int LAT = 4;
  localparam logic [3:0] CFG_COEF_BASE = 4'd0;
  localparam logic [3:0] CFG_OFF_BASE = 4'd9;
  // BT.601 full-range RGB->YCbCr, row-major, Q2.16
  localparam int DEF_COEF [9] = '{19595, 38470, 7471, -11059, -21709, 32768, 32768, -27439, -5329};
  // Offsets at 8 bits per channel; scaled by PIX_W-8 at the point of use
  localparam int DEF_OFF [3] = '{0, 128, 128};
endpackage

// File: rtl/csc_mac_row.sv
// csc_mac_row: one output row of the 3x3 matrix (multiply, add tree, offset/round, clamp or wrap via CSC_CLAMP_EN)
module csc_mac_row
  import csc_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OFF_W = PIX_W + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*PIX_W-1:0]     pix,
  input  logic [2:0][COEF_W-1:0] coef,
  input  logic [OFF_W-1:0]       off,
  output logic [PIX_W-1:0]       y
);
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int ACC_W = PIX_W + COEF_W + 3;
  logic signed [PROD_W-1:0] p_q [3], p_d [3];
  logic signed [PROD_W-1:0] p2_q, p2_d;
  logic signed [OFF_W-1:0] off1_q, off1_d, off2_q, off2_d;
  logic signed [ACC_W-1:0] s01_q, s01_d, acc_q, acc_d;
  // Stage 1 products (channels zero-extended), stage 2 partial sum, stage 3 sum with offset and half-LSB rounding
  always_comb begin
    for (int c = 0; c < 3; c++)
      p_d[c] = PROD_W'(signed'(coef[c])) * PROD_W'(signed'({1'b0, pix[(2-c)*PIX_W +: PIX_W]}));
    off1_d = off;
    s01_d = ACC_W'(p_q[0]) + ACC_W'(p_q[1]);
    p2_d = p_q[2];
    off2_d = off1_q;
    acc_d = s01_q + ACC_W'(p2_q) + (ACC_W'(off2_q) <<< FRAC_W) + (ACC_W'(1) <<< (FRAC_W - 1));
  end
  // Pipeline registers; the offset travels with its products so a bank swap never splits a pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= '{default: '0};
      off1_q <= '0;
      s01_q <= '0;
      p2_q <= '0;
      off2_q <= '0;
      acc_q <= '0;
    end else begin
      p_q <= p_d;
      off1_q <= off1_d;
      s01_q <= s01_d;
      p2_q <= p2_d;
      off2_q <= off2_d;
      acc_q <= acc_d;
    end
  end
`ifdef CSC_CLAMP_EN
  localparam int SH_W = ACC_W - FRAC_W;
  logic signed [SH_W-1:0] sh;
  // Stage 4 input: drop the fraction and saturate to [0, 2^PIX_W-1]
  always_comb begin
    sh = SH_W'(acc_q >>> FRAC_W);
    y = sh[SH_W-1] ? '0 : (|sh[SH_W-2:PIX_W]) ? '1 : sh[PIX_W-1:0];
  end
`else
  // Stage 4 input: drop the fraction and keep the low PIX_W bits (wraps)
  always_comb y = PIX_W'(acc_q >>> FRAC_W);
`endif
endmodule

// File: rtl/csc_matrix_pipe.sv
// csc_matrix_pipe: programmable 3x3 colour-space converter, 4-cycle pipeline, shadow/active banks swapped on v_sync rise, clamp via CSC_CLAMP_EN
module csc_matrix_pipe
  import csc_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OFF_W = PIX_W + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [3*PIX_W-1:0] pixel_in,
  input  logic               bypass,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [COEF_W-1:0]  cfg_wdata,
  input  logic               cfg_commit,
  output logic               cfg_pending,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [3*PIX_W-1:0] pixel_out
);
  logic [8:0][COEF_W-1:0] coef_q, coef_d, shc_q, shc_d;
  logic [2:0][OFF_W-1:0] off_q, off_d, sho_q, sho_d;
  logic pend_q, pend_d, apply;
  logic [LAT-1:0][2:0] tim_q, tim_d;
  logic [2:0][3*PIX_W-1:0] pixd_q, pixd_d;
  logic [2:0] byp_q, byp_d;
  logic [3*PIX_W-1:0] out_q, out_d;
  logic [PIX_W-1:0] y [3];
  for (genvar r = 0; r < 3; r++) begin : g_row
    csc_mac_row #(.PIX_W(PIX_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .OFF_W(OFF_W)) u_row (
      .clk(clk),
      .rst_n(rst_n),
      .pix(pixel_in),
      .coef(coef_q[3*r +: 3]),
      .off(off_q[r]),
      .y(y[r])
    );
  end
  // Commit arms on cfg_commit; the copy happens on a v_sync rise, before any same-cycle shadow write
  always_comb begin
    apply = (pend_q | cfg_commit) & v_sync_in & ~tim_q[0][0];
    pend_d = ~apply & (pend_q | cfg_commit);
    coef_d = apply ? shc_q : coef_q;
    off_d = apply ? sho_q : off_q;
    for (int i = 0; i < 9; i++)
      shc_d[i] = (cfg_we && cfg_addr == CFG_COEF_BASE + 4'(i)) ? cfg_wdata : shc_q[i];
    for (int i = 0; i < 3; i++)
      sho_d[i] = (cfg_we && cfg_addr == CFG_OFF_BASE + 4'(i)) ? cfg_wdata[OFF_W-1:0] : sho_q[i];
  end
  // Timing and raw-pixel delay lines; bypass selects the raw pixel at the output stage
  always_comb begin
    tim_d = {tim_q[LAT-2:0], de_in, h_sync_in, v_sync_in};
    pixd_d = {pixd_q[1:0], pixel_in};
    byp_d = {byp_q[1:0], bypass};
    out_d = byp_q[2] ? pixd_q[2] : {y[0], y[1], y[2]};
  end
  // State registers; reset restores the BT.601 banks in both active and shadow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= COEF_W'(DEF_COEF[i]);
        shc_q[i] <= COEF_W'(DEF_COEF[i]);
      end
      for (int i = 0; i < 3; i++) begin
        off_q[i] <= OFF_W'(DEF_OFF[i] << (PIX_W - 8));
        sho_q[i] <= OFF_W'(DEF_OFF[i] << (PIX_W - 8));
      end
      pend_q <= 1'b0;
      tim_q <= '0;
      pixd_q <= '0;
      byp_q <= '0;
      out_q <= '0;
    end else begin
      coef_q <= coef_d;
      shc_q <= shc_d;
      off_q <= off_d;
      sho_q <= sho_d;
      pend_q <= pend_d;
      tim_q <= tim_d;
      pixd_q <= pixd_d;
      byp_q <= byp_d;
      out_q <= out_d;
    end
  end
  assign cfg_pending = pend_q;
  assign {de_out, h_sync_out, v_sync_out} = tim_q[LAT-1];
  assign pixel_out = out_q;
endmodule

// File: tb/tb_csc_matrix_pipe.sv
// tb_csc_matrix_pipe: table vectors, directed bank/bypass/reset sequences and random stimulus against a behavioural model
module tb_csc_matrix_pipe;
  logic clk = 1'b0;
  logic rst_n, de_in, h_sync_in, v_sync_in, bypass, cfg_we, cfg_commit;
  logic [23:0] pixel_in, pixel_out;
  logic [3:0] cfg_addr;
  logic [17:0] cfg_wdata;
  logic cfg_pending, de_out, h_sync_out, v_sync_out;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    bit rn, de, hs, vs, byp, we, cm, tab;
    logic [23:0] px, exp;
    logic [3:0] a;
    logic [17:0] d;
  } in_t;
  typedef struct packed {
    logic [2:0] tim;
    logic [23:0] pix;
    logic tab;
    logic [23:0] texp;
  } exp_t;

  exp_t q[$];
  int m_coef[9], m_off[3], s_coef[9], s_off[3];
  bit m_pend, m_vs;
  in_t tv[8];

  always #5 clk = ~clk;

  csc_matrix_pipe dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pixel_in(pixel_in), .bypass(bypass), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  function automatic void reset_model();
    m_coef = '{19595, 38470, 7471, -11059, -21709, 32768, 32768, -27439, -5329};
    m_off = '{0, 128, 128};
    s_coef = m_coef;
    s_off = m_off;
    m_pend = 0;
    m_vs = 0;
  endfunction

  function automatic logic [23:0] ref_px(logic [23:0] p, bit byp);
    logic [23:0] r;
    longint acc;
    if (byp) return p;
    for (int row = 0; row < 3; row++) begin
      acc = 32768 + longint'(m_off[row]) * 65536;
      for (int c = 0; c < 3; c++) acc += longint'(m_coef[3*row+c]) * longint'(p[(2-c)*8 +: 8]);
      acc = acc >>> 16;
`ifdef CSC_CLAMP_EN
      acc = acc < 0 ? 0 : acc > 255 ? 255 : acc;
`endif
      r[(2-row)*8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  function automatic in_t v(logic [23:0] px, bit byp = 0, bit de = 1, bit hs = 0, bit vs = 0);
    in_t t;
    t = '{default: 0};
    t.rn = 1;
    t.px = px;
    t.byp = byp;
    t.de = de;
    t.hs = hs;
    t.vs = vs;
    return t;
  endfunction

  function automatic in_t vt(logic [23:0] px, logic [23:0] e, bit byp = 0, bit vs = 0);
    in_t t;
    t = v(px, byp, 1, 0, vs);
    t.tab = 1;
    t.exp = e;
    return t;
  endfunction

  function automatic in_t cw(logic [3:0] a, logic [17:0] d, bit cm = 0, bit vs = 0);
    in_t t;
    t = v(24'h808080, 0, 1, 0, vs);
    t.we = 1;
    t.a = a;
    t.d = d;
    t.cm = cm;
    return t;
  endfunction

  // One clock: check what is due now, then drive the next inputs and advance the model
  task automatic cyc(input in_t t);
    exp_t e, n;
    bit ap;
    @(negedge clk);
    e = q.pop_front();
    chk("pixel", 32'(pixel_out), 32'(e.pix));
    chk("timing", 32'({de_out, h_sync_out, v_sync_out}), 32'(e.tim));
    chk("pending", 32'(cfg_pending), 32'(m_pend));
    if (e.tab) chk("table", 32'(pixel_out), 32'(e.texp));
    rst_n = t.rn; de_in = t.de; h_sync_in = t.hs; v_sync_in = t.vs;
    pixel_in = t.px; bypass = t.byp; cfg_we = t.we; cfg_addr = t.a;
    cfg_wdata = t.d; cfg_commit = t.cm;
    if (!t.rn) begin
      reset_model();
      q.delete();
      repeat (4) q.push_back('0);
    end else begin
      n.tim = {t.de, t.hs, t.vs};
      n.pix = ref_px(t.px, t.byp);
      n.tab = t.tab;
      n.texp = t.exp;
      q.push_back(n);
      ap = (m_pend || t.cm) && t.vs && !m_vs;
      if (ap) begin
        m_coef = s_coef;
        m_off = s_off;
      end
      if (t.we && t.a < 9) s_coef[t.a] = int'($signed(t.d));
      else if (t.we && t.a < 12) s_off[t.a-9] = int'($signed(t.d[9:0]));
      m_pend = !ap && (m_pend || t.cm);
      m_vs = t.vs;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(v(24'h0, 0, 0));
  endtask

  task automatic load_identity(input bit cm);
    for (int i = 0; i < 9; i++) cyc(cw(4'(i), (i % 4 == 0) ? 18'd65536 : 18'd0));
    for (int i = 9; i < 12; i++) cyc(cw(4'(i), 18'd0, cm && i == 11));
  endtask

  initial begin
    logic [23:0] rp;
    in_t t;
    rst_n = 0; de_in = 0; h_sync_in = 0; v_sync_in = 0; pixel_in = '0;
    bypass = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 0;
    repeat (2) @(negedge clk);
    reset_model();
    repeat (4) q.push_back('0);
    tv[0] = vt(24'hFFFFFF, 24'hFF8080);
    tv[1] = vt(24'h000000, 24'h008080);
`ifdef CSC_CLAMP_EN
    tv[2] = vt(24'hFF0000, 24'h4C55FF);
    tv[5] = vt(24'h0000FF, 24'h1DFF6B);
`else
    tv[2] = vt(24'hFF0000, 24'h4C5500);
    tv[5] = vt(24'h0000FF, 24'h1D006B);
`endif
    tv[3] = vt(24'h123456, 24'h123456, 1);
    tv[4] = vt(24'h00FF00, 24'h962C15);
    tv[6] = vt(24'hFFFFFF, 24'hFF8080);
    tv[6].hs = 1;
    tv[7] = vt(24'hABCDEF, 24'hABCDEF, 1);
    tv[7].vs = 1;
    idle(2);
    for (int i = 0; i < 8; i++) cyc(tv[i]);
    idle(4);
    // bypass toggling every cycle on a ramp
    for (int i = 0; i < 16; i++) begin
      rp = {8'(i * 16), 8'(255 - i * 16), 8'(i * 5)};
      t = v(rp, i[0], 1, i == 0);
      t.tab = i[0];
      t.exp = rp;
      cyc(t);
    end
    idle(4);
    // identity loaded and committed mid-frame; BT.601 holds until v_sync rises
    load_identity(1);
    cyc(vt(24'hFFFFFF, 24'hFF8080));
    cyc(vt(24'hFFFFFF, 24'hFF8080));
    cyc(v(24'h0C2238, 0, 1, 0, 1));
    cyc(vt(24'h0C2238, 24'h0C2238, 0, 1));
    cyc(vt(24'hFF0000, 24'hFF0000));
    idle(4);
    // reset mid-line with identity active reverts to BT.601
    cyc(v(24'h445566));
    t = v(24'h778899);
    t.rn = 0;
    cyc(t);
    idle(2);
    cyc(vt(24'hFFFFFF, 24'hFF8080));
    idle(4);
    // ignored address plus commit on the v_sync edge itself
    load_identity(0);
    cyc(cw(4'd13, 18'h3ABCD, 1, 1));
    cyc(vt(24'h0C2238, 24'h0C2238, 0, 1));
    cyc(vt(24'h00FF00, 24'h00FF00));
    idle(4);
    // random traffic, config writes, commits, v_sync edges and resets
    for (int i = 0; i < 800; i++) begin
      t = v(24'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0) ? !m_vs : m_vs);
      t.we = $urandom_range(0, 3) == 0;
      t.a = 4'($urandom_range(0, 15));
      t.d = 18'($urandom);
      t.cm = $urandom_range(0, 15) == 0;
      t.rn = $urandom_range(0, 199) != 0;
      cyc(t);
    end
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
